// File: rtl/nibble_sequencer.sv
// nibble_sequencer: FETCH/EXEC/HALT control unit for the 4-bit processor.
// Latches an 8-bit instruction from ROM, then issues one-cycle strobes to the
// PC, accumulator, ALU and output port. It also keeps the carry/zero flags
// that the conditional jumps test.
// Optional feature macro: NIBBLE_SEQ_STEP_EN adds a `step` input that gates
// each fetch. With the macro defined, fetches happen only when step is high.
module nibble_sequencer #(
  parameter int FETCH_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
`ifdef NIBBLE_SEQ_STEP_EN
  input  logic       step,
`endif
  input  logic [7:0] instr,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic       pc_en,
  output logic       pc_load,
  output logic       acc_en,
  output logic [2:0] alu_sel,
  output logic [1:0] bus_src,
  output logic       out_en,
  output logic [3:0] operand,
  output logic       flag_c,
  output logic       flag_z,
  output logic       halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [1:0] WAIT_LAST = 2'(FETCH_WAIT);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] ir;
  logic [1:0] cnt;
  logic [3:0] opcode;
  logic       step_ok;
  logic       fetch_go;

`ifdef NIBBLE_SEQ_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  assign opcode   = ir[7:4];
  assign operand  = ir[3:0];
  assign halted   = (state == HALT);
  assign fetch_go = (state == FETCH) && (cnt == WAIT_LAST) && step_ok;

  // Next-state and strobe decode. The strobes come from registered state and
  // IR, and reset forces them low.
  always_comb begin
    state_nxt = state;
    pc_en     = 1'b0;
    pc_load   = 1'b0;
    acc_en    = 1'b0;
    alu_sel   = 3'b000;
    bus_src   = 2'b00;
    out_en    = 1'b0;
    case (state)
      FETCH: begin
        if (fetch_go) begin
          pc_en     = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = FETCH;
        case (opcode)
          4'h1: acc_en = 1'b1;
          4'h2: begin acc_en = 1'b1; bus_src = 2'b01; alu_sel = 3'b001; end
          4'h3: begin acc_en = 1'b1; bus_src = 2'b01; alu_sel = 3'b010; end
          4'h4: begin acc_en = 1'b1; bus_src = 2'b01; alu_sel = 3'b011; end
          4'h5: begin acc_en = 1'b1; bus_src = 2'b01; alu_sel = 3'b100; end
          4'h6: alu_sel = 3'b010;
          4'h7: out_en = 1'b1;
          4'h8: begin acc_en = 1'b1; bus_src = 2'b10; end
          4'h9: pc_load = 1'b1;
          4'hA: pc_load = flag_c;
          4'hB: pc_load = flag_z;
          4'hC: pc_load = ~flag_c;
          4'hD: pc_load = ~flag_z;
          4'hF: state_nxt = HALT;
          default: ;
        endcase
      end
      HALT: state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
    if (reset) begin
      pc_en   = 1'b0;
      pc_load = 1'b0;
      acc_en  = 1'b0;
      alu_sel = 3'b000;
      bus_src = 2'b00;
      out_en  = 1'b0;
    end
  end

  // State, IR, wait counter and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      ir     <= 8'h00;
      cnt    <= 2'd0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == FETCH) begin
        if (fetch_go) begin
          ir  <= instr;
          cnt <= 2'd0;
        end else if (cnt != WAIT_LAST) begin
          cnt <= cnt + 2'd1;
        end
      end
      if (state == EXEC) begin
        case (opcode)
          4'h2, 4'h3, 4'h6: begin
            flag_z <= alu_zero;
            flag_c <= alu_carry;
          end
          4'h4, 4'h5: begin
            flag_z <= alu_zero;
            flag_c <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nibble_sequencer.sv
// Scoreboard bench for nibble_sequencer. Two instances (FETCH_WAIT 0 and 2)
// share one input stream. A behavioural instruction-level model predicts every
// cycle's outputs into per-instance queues, and a monitor checks them.
module tb_nibble_sequencer;

  typedef struct packed {
    logic       pc_en;
    logic       pc_load;
    logic       acc_en;
    logic [2:0] alu_sel;
    logic [1:0] bus_src;
    logic       out_en;
    logic [3:0] operand;
    logic       flag_c;
    logic       flag_z;
    logic       halted;
  } obs_t;

  typedef struct packed {
    logic       halted;
    logic       in_exec;
    logic [7:0] ir;
    logic       fc;
    logic       fz;
    logic [2:0] waited;
  } mst_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       step;
  logic [7:0] instr;
  logic       alu_carry;
  logic       alu_zero;

  logic       pc_en0, pc_load0, acc_en0, out_en0, flag_c0, flag_z0, halted0;
  logic [2:0] alu_sel0;
  logic [1:0] bus_src0;
  logic [3:0] operand0;
  logic       pc_en2, pc_load2, acc_en2, out_en2, flag_c2, flag_z2, halted2;
  logic [2:0] alu_sel2;
  logic [1:0] bus_src2;
  logic [3:0] operand2;

  obs_t act0, act2;
  obs_t q0[$];
  obs_t q2[$];
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  nibble_sequencer #(.FETCH_WAIT(0)) dut0 (
    .clk(clk), .reset(reset),
`ifdef NIBBLE_SEQ_STEP_EN
    .step(step),
`endif
    .instr(instr), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .pc_en(pc_en0), .pc_load(pc_load0), .acc_en(acc_en0), .alu_sel(alu_sel0),
    .bus_src(bus_src0), .out_en(out_en0), .operand(operand0),
    .flag_c(flag_c0), .flag_z(flag_z0), .halted(halted0)
  );

  nibble_sequencer #(.FETCH_WAIT(2)) dut2 (
    .clk(clk), .reset(reset),
`ifdef NIBBLE_SEQ_STEP_EN
    .step(step),
`endif
    .instr(instr), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .pc_en(pc_en2), .pc_load(pc_load2), .acc_en(acc_en2), .alu_sel(alu_sel2),
    .bus_src(bus_src2), .out_en(out_en2), .operand(operand2),
    .flag_c(flag_c2), .flag_z(flag_z2), .halted(halted2)
  );

  assign act0 = {pc_en0, pc_load0, acc_en0, alu_sel0, bus_src0, out_en0,
                 operand0, flag_c0, flag_z0, halted0};
  assign act2 = {pc_en2, pc_load2, acc_en2, alu_sel2, bus_src2, out_en2,
                 operand2, flag_c2, flag_z2, halted2};

  // Instruction-level reference: returns this cycle's outputs and the next state.
  function automatic void model_step(input mst_t s, input logic rst, input logic [7:0] ins,
                                     input logic c, input logic z, input logic stp,
                                     input int fw, output obs_t e, output mst_t n);
    logic [3:0] op;
    e = '0;
    e.operand = s.ir[3:0];
    e.flag_c  = s.fc;
    e.flag_z  = s.fz;
    e.halted  = s.halted;
    n  = s;
    op = s.ir[7:4];
    if (rst) begin
      n = '0;
      return;
    end
    if (s.halted) return;
    if (!s.in_exec) begin
      if (int'(s.waited) >= fw && stp) begin
        e.pc_en   = 1'b1;
        n.ir      = ins;
        n.in_exec = 1'b1;
        n.waited  = 3'd0;
      end else if (int'(s.waited) < fw) begin
        n.waited = s.waited + 3'd1;
      end
      return;
    end
    n.in_exec = 1'b0;
    if (op == 4'h1) e.acc_en = 1'b1;
    if (op >= 4'h2 && op <= 4'h5) begin
      e.acc_en  = 1'b1;
      e.bus_src = 2'b01;
      e.alu_sel = 3'(op - 4'h1);
    end
    if (op == 4'h6) e.alu_sel = 3'b010;
    if (op == 4'h7) e.out_en = 1'b1;
    if (op == 4'h8) begin
      e.acc_en  = 1'b1;
      e.bus_src = 2'b10;
    end
    if (op == 4'h9) e.pc_load = 1'b1;
    if (op == 4'hA) e.pc_load = s.fc;
    if (op == 4'hB) e.pc_load = s.fz;
    if (op == 4'hC) e.pc_load = !s.fc;
    if (op == 4'hD) e.pc_load = !s.fz;
    if (op >= 4'h2 && op <= 4'h6) begin
      n.fz = z;
      n.fc = (op == 4'h4 || op == 4'h5) ? 1'b0 : c;
    end
    if (op == 4'hF) n.halted = 1'b1;
  endfunction

  task automatic compare(input int fw, input obs_t got, input obs_t exp);
    n_chk++;
    if (got !== exp || (got.pc_en && got.pc_load)) begin
      $display("FAIL outputs_fw%0d t=%0t got pc_en=%b pc_load=%b acc_en=%b alu_sel=%b bus_src=%b out_en=%b operand=%h c=%b z=%b halted=%b expected pc_en=%b pc_load=%b acc_en=%b alu_sel=%b bus_src=%b out_en=%b operand=%h c=%b z=%b halted=%b",
               fw, $time, got.pc_en, got.pc_load, got.acc_en, got.alu_sel, got.bus_src,
               got.out_en, got.operand, got.flag_c, got.flag_z, got.halted,
               exp.pc_en, exp.pc_load, exp.acc_en, exp.alu_sel, exp.bus_src,
               exp.out_en, exp.operand, exp.flag_c, exp.flag_z, exp.halted);
    end else begin
      n_pass++;
    end
  endtask

  // Monitor: pops predictions and compares them on the falling edge.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        compare(0, act0, e);
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        compare(2, act2, e);
      end
    end
  end

  // Stimulus: a directed program, then randomized traffic with random resets.
  initial begin
    logic [7:0] prog [0:8];
    mst_t m0, m2, n0, n2;
    obs_t e0, e2;
    int   k;
    prog[0] = 8'h15; prog[1] = 8'h23; prog[2] = 8'h70;
    prog[3] = 8'h33; prog[4] = 8'hB8; prog[5] = 8'h40;
    prog[6] = 8'hD2; prog[7] = 8'hA4; prog[8] = 8'hF0;
    reset = 1'b1; step = 1'b1; instr = 8'h00; alu_carry = 1'b0; alu_zero = 1'b0;
    repeat (2) @(posedge clk);
    m0 = '0;
    m2 = '0;
    k  = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc < 30) begin
        reset     = 1'b0;
        step      = 1'b1;
        instr     = prog[k];
        alu_carry = (m0.ir == 8'h33);
        alu_zero  = (m0.ir == 8'h33);
      end else if (cyc == 30) begin
        reset = 1'b1;
      end else begin
        reset = ($urandom_range(0, 49) == 0) || (m0.halted && m2.halted);
        instr = 8'($urandom);
        if (instr[7:4] == 4'hF && $urandom_range(0, 1) == 0) instr[7:4] = 4'h2;
        alu_carry = 1'($urandom);
        alu_zero  = 1'($urandom);
`ifdef NIBBLE_SEQ_STEP_EN
        if (cyc >= 40 && cyc < 52) step = 1'b0;
        else step = ($urandom_range(0, 9) < 7);
`endif
      end
      model_step(m0, reset, instr, alu_carry, alu_zero, step, 0, e0, n0);
      model_step(m2, reset, instr, alu_carry, alu_zero, step, 2, e2, n2);
      q0.push_back(e0);
      q2.push_back(e2);
      if (cyc < 30 && e0.pc_en && k < 8) k++;
      m0 = n0;
      m2 = n2;
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (q0.size() != 0 || q2.size() != 0)
      $display("FAIL scoreboard_drain left=%0d required=0", q0.size() + q2.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
